// File: rtl/jelly_cpu_alu_divider_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jelly_cpu_alu_divider_seq_pkg
//  Description : Shared encodings for the sequential DIV/DIVU engine:
//                FSM state codes and the ALU adder function codes it issues.
//  Revision    : 1.0  initial release
// ============================================================================
package jelly_cpu_alu_divider_seq_pkg;

    // FSM state encodings
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_NEG_A = 3'd1;
    localparam logic [2:0] c_ST_NEG_B = 3'd2;
    localparam logic [2:0] c_ST_DIV   = 3'd3;
    localparam logic [2:0] c_ST_FIX_Q = 3'd4;
    localparam logic [2:0] c_ST_FIX_R = 3'd5;
    localparam logic [2:0] c_ST_DONE  = 3'd6;

    // ALU adder function codes (must match the core ALU definitions)
    localparam logic [1:0] c_ALU_ADD  = 2'b00;
    localparam logic [1:0] c_ALU_SUB  = 2'b01;

endpackage
`default_nettype wire

// File: rtl/jelly_cpu_alu_divider_seq.sv
`default_nettype none
// ============================================================================
//  Module      : jelly_cpu_alu_divider_seq
//  Description : Multi-cycle restoring divider for MIPS DIV/DIVU. Borrows the
//                core ALU adder (muxed in by busy) for operand negation, one
//                trial subtraction per quotient bit, and sign fix-up.
//  Revision    : 1.0  initial release
// ============================================================================
module jelly_cpu_alu_divider_seq
    import jelly_cpu_alu_divider_seq_pkg::*;
#(
    parameter int DATA_SIZE  = 5,
    parameter int DATA_WIDTH = 1 << DATA_SIZE
)
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cancel,

    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_signed,
    input  logic [DATA_WIDTH-1:0]   s_data0,
    input  logic [DATA_WIDTH-1:0]   s_data1,

    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_quotient,
    output logic [DATA_WIDTH-1:0]   m_remainder,

    output logic                    busy,

    output logic [1:0]              alu_adder_func,
    output logic [DATA_WIDTH-1:0]   alu_in_data0,
    output logic [DATA_WIDTH-1:0]   alu_in_data1,
    input  logic [DATA_WIDTH-1:0]   alu_out_data,
    input  logic                    alu_out_carry
);

    localparam logic [DATA_SIZE-1:0] c_CNT_LAST = DATA_SIZE'(DATA_WIDTH - 1);

    logic [2:0]              state_q,       state_d;
    logic                    sign_a_q,      sign_a_d;
    logic                    sign_b_q,      sign_b_d;
    logic [DATA_WIDTH-1:0]   dividend_q,    dividend_d;   // becomes the quotient
    logic [DATA_WIDTH-1:0]   divisor_q,     divisor_d;
    logic [DATA_WIDTH-1:0]   rem_q,         rem_d;
    logic [DATA_SIZE-1:0]    cnt_q,         cnt_d;
    logic                    m_valid_q,     m_valid_d;
    logic [DATA_WIDTH-1:0]   m_quotient_q,  m_quotient_d;
    logic [DATA_WIDTH-1:0]   m_remainder_q, m_remainder_d;

    // Partial remainder shifted left with the next dividend bit brought in
    logic [DATA_WIDTH-1:0]   w_shifted;
    // Quotient bit: a set rem MSB means the true W+1-bit value exceeds the divisor
    logic                    w_qbit;
    logic [DATA_WIDTH-1:0]   w_rem_fixed;

    assign w_shifted   = {rem_q[DATA_WIDTH-2:0], dividend_q[DATA_WIDTH-1]};
    assign w_qbit      = rem_q[DATA_WIDTH-1] | alu_out_carry;
    assign w_rem_fixed = sign_a_q ? alu_out_data : rem_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= c_ST_IDLE;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            dividend_q    <= '0;
            divisor_q     <= '0;
            rem_q         <= '0;
            cnt_q         <= '0;
            m_valid_q     <= 1'b0;
            m_quotient_q  <= '0;
            m_remainder_q <= '0;
        end else begin
            state_q       <= state_d;
            sign_a_q      <= sign_a_d;
            sign_b_q      <= sign_b_d;
            dividend_q    <= dividend_d;
            divisor_q     <= divisor_d;
            rem_q         <= rem_d;
            cnt_q         <= cnt_d;
            m_valid_q     <= m_valid_d;
            m_quotient_q  <= m_quotient_d;
            m_remainder_q <= m_remainder_d;
        end
    end

    // Next-state sequencing; cancel overrides everything
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:  if (s_valid) state_d = c_ST_NEG_A;
            c_ST_NEG_A: state_d = c_ST_NEG_B;
            c_ST_NEG_B: state_d = c_ST_DIV;
            c_ST_DIV:   if (cnt_q == '0) state_d = c_ST_FIX_Q;
            c_ST_FIX_Q: state_d = c_ST_FIX_R;
            c_ST_FIX_R: state_d = c_ST_DONE;
            c_ST_DONE:  if (m_ready) state_d = c_ST_IDLE;
            default:    state_d = c_ST_IDLE;
        endcase
        if (cancel) begin
            state_d = c_ST_IDLE;
        end
    end

    // Datapath updates, consuming the ALU result of the current cycle
    always_comb begin
        sign_a_d      = sign_a_q;
        sign_b_d      = sign_b_q;
        dividend_d    = dividend_q;
        divisor_d     = divisor_q;
        rem_d         = rem_q;
        cnt_d         = cnt_q;
        m_valid_d     = m_valid_q;
        m_quotient_d  = m_quotient_q;
        m_remainder_d = m_remainder_q;
        case (state_q)
            c_ST_IDLE: begin
                if (s_valid) begin
                    dividend_d = s_data0;
                    divisor_d  = s_data1;
                    sign_a_d   = s_signed & s_data0[DATA_WIDTH-1];
                    sign_b_d   = s_signed & s_data1[DATA_WIDTH-1];
                end
            end
            c_ST_NEG_A: begin
                if (sign_a_q) dividend_d = alu_out_data;
            end
            c_ST_NEG_B: begin
                if (sign_b_q) divisor_d = alu_out_data;
                rem_d = '0;
                cnt_d = c_CNT_LAST;
            end
            c_ST_DIV: begin
                rem_d      = w_qbit ? alu_out_data : w_shifted;
                dividend_d = {dividend_q[DATA_WIDTH-2:0], w_qbit};
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            c_ST_FIX_Q: begin
                if (sign_a_q ^ sign_b_q) dividend_d = alu_out_data;
            end
            c_ST_FIX_R: begin
                rem_d         = w_rem_fixed;
                m_quotient_d  = dividend_q;
                m_remainder_d = w_rem_fixed;
                m_valid_d     = 1'b1;
            end
            c_ST_DONE: begin
                if (m_ready) m_valid_d = 1'b0;
            end
            default: ;
        endcase
        if (cancel) begin
            m_valid_d = 1'b0;
        end
    end

    // ALU request and handshake outputs, driven from registers only
    always_comb begin
        alu_adder_func = c_ALU_ADD;
        alu_in_data0   = '0;
        alu_in_data1   = '0;
        case (state_q)
            c_ST_NEG_A: begin
                alu_adder_func = c_ALU_SUB;
                alu_in_data1   = dividend_q;
            end
            c_ST_NEG_B: begin
                alu_adder_func = c_ALU_SUB;
                alu_in_data1   = divisor_q;
            end
            c_ST_DIV: begin
                alu_adder_func = c_ALU_SUB;
                alu_in_data0   = w_shifted;
                alu_in_data1   = divisor_q;
            end
            c_ST_FIX_Q: begin
                alu_adder_func = c_ALU_SUB;
                alu_in_data1   = dividend_q;
            end
            c_ST_FIX_R: begin
                alu_adder_func = c_ALU_SUB;
                alu_in_data1   = rem_q;
            end
            default: ;
        endcase
    end

    assign s_ready     = (state_q == c_ST_IDLE);
    assign busy        = (state_q != c_ST_IDLE);
    assign m_valid     = m_valid_q;
    assign m_quotient  = m_quotient_q;
    assign m_remainder = m_remainder_q;

endmodule
`default_nettype wire

// File: tb/tb_jelly_cpu_alu_divider_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_jelly_cpu_alu_divider_seq
//  Description : Self-checking bench for the sequential divider, with a
//                behavioural model of the shared ALU adder and a result
//                scoreboard fed from an independent reference divider.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_jelly_cpu_alu_divider_seq;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } res_t;

    logic          clk;
    logic          reset_n;
    logic          cancel;
    logic          s_valid;
    logic          s_ready;
    logic          s_signed;
    logic [W-1:0]  s_data0;
    logic [W-1:0]  s_data1;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_quotient;
    logic [W-1:0]  m_remainder;
    logic          busy;
    logic [1:0]    alu_adder_func;
    logic [W-1:0]  alu_in_data0;
    logic [W-1:0]  alu_in_data1;
    logic [W-1:0]  alu_out_data;
    logic          alu_out_carry;

    int   n_vec;
    int   n_err;
    res_t sb_q[$];

    jelly_cpu_alu_divider_seq #(.DATA_SIZE(5), .DATA_WIDTH(W)) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cancel         (cancel),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_signed       (s_signed),
        .s_data0        (s_data0),
        .s_data1        (s_data1),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_quotient     (m_quotient),
        .m_remainder    (m_remainder),
        .busy           (busy),
        .alu_adder_func (alu_adder_func),
        .alu_in_data0   (alu_in_data0),
        .alu_in_data1   (alu_in_data1),
        .alu_out_data   (alu_out_data),
        .alu_out_carry  (alu_out_carry)
    );

    // Behavioural ALU adder: SUB is in0 + ~in1 + 1, carry=1 means no borrow
    logic [W:0] w_alu_full;
    assign w_alu_full = {1'b0, alu_in_data0}
                      + {1'b0, (alu_adder_func == 2'b01) ? ~alu_in_data1 : alu_in_data1}
                      + {{W{1'b0}}, (alu_adder_func == 2'b01)};
    assign alu_out_data  = w_alu_full[W-1:0];
    assign alu_out_carry = w_alu_full[W];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference MIPS divide including the defined div-by-zero and overflow cases
    function automatic res_t ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t res;
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        if (!sgn) begin
            if (b == '0) begin res.q = '1; res.r = a; end
            else begin res.q = a / b; res.r = a % b; end
        end else begin
            if (b == '0) begin
                res.q = sa[W-1] ? W'(1) : '1;
                res.r = a;
            end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
                res.q = a;
                res.r = '0;
            end else begin
                res.q = W'(sa / sb);
                res.r = W'(sa % sb);
            end
        end
        return res;
    endfunction

    function automatic logic [W-1:0] rand_val(input bit small_bias);
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return W'($urandom_range(1, 15));
            4:       return small_bias ? W'($urandom_range(1, 1000)) : W'($urandom);
            default: return W'($urandom);
        endcase
    endfunction

    // Present one operand set and return right after the accepting edge
    task automatic send(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check_value("s_ready_wait", {63'd0, s_ready}, 64'd1);
        s_valid  = 1'b1;
        s_signed = sgn;
        s_data0  = a;
        s_data1  = b;
        @(posedge clk);
    endtask

    // Full transaction: latency, busy/s_ready during the run, back-pressure, result
    task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input bit junk, input string tag);
        res_t exp;
        res_t got;
        int   edges;
        bit   seen;
        send(sgn, a, b);
        sb_q.push_back(ref_div(sgn, a, b));
        seen  = 1'b0;
        edges = 0;
        for (int i = 0; i < W + 12; i++) begin
            @(negedge clk);
            if (m_valid) begin
                edges = i;
                seen  = 1'b1;
                break;
            end
            check_value({tag, "_busy"},   {63'd0, busy},    64'd1);
            check_value({tag, "_sready"}, {63'd0, s_ready}, 64'd0);
            s_valid  = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            s_signed = 1'($urandom_range(0, 1));
            s_data0  = W'($urandom);
            s_data1  = W'($urandom);
        end
        s_valid = 1'b0;
        check_value({tag, "_seen"},    {63'd0, seen}, 64'd1);
        check_value({tag, "_latency"}, 64'(edges),    64'(W + 4));
        if (!seen) begin
            void'(sb_q.pop_front());
            return;
        end
        for (int h = 0; h < hold; h++) begin
            check_value({tag, "_hold_valid"}, {63'd0, m_valid}, 64'd1);
            check_value({tag, "_hold_q"},     64'(m_quotient),  64'(sb_q[0].q));
            check_value({tag, "_hold_r"},     64'(m_remainder), 64'(sb_q[0].r));
            @(negedge clk);
        end
        m_ready = 1'b1;
        exp = sb_q.pop_front();
        got.q = m_quotient;
        got.r = m_remainder;
        check_value({tag, "_valid"}, {63'd0, m_valid}, 64'd1);
        check_value({tag, "_q"},     64'(got.q),       64'(exp.q));
        check_value({tag, "_r"},     64'(got.r),       64'(exp.r));
        @(negedge clk);
        m_ready = 1'b0;
        check_value({tag, "_post_valid"},  {63'd0, m_valid}, 64'd0);
        check_value({tag, "_post_sready"}, {63'd0, s_ready}, 64'd1);
        check_value({tag, "_post_busy"},   {63'd0, busy},    64'd0);
    endtask

    initial begin
        bit any_valid;
        logic sgn;
        logic [W-1:0] a, b;

        n_vec    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        cancel   = 1'b0;
        s_valid  = 1'b0;
        s_signed = 1'b0;
        s_data0  = '0;
        s_data1  = '0;
        m_ready  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_value("rst_sready", {63'd0, s_ready}, 64'd1);
        check_value("rst_mvalid", {63'd0, m_valid}, 64'd0);
        check_value("rst_busy",   {63'd0, busy},    64'd0);
        check_value("rst_q",      64'(m_quotient),  64'd0);
        check_value("rst_r",      64'(m_remainder), 64'd0);
        reset_n = 1'b1;

        // Directed cases
        run_op(1'b0, 32'd100,        32'd7,        5, 1'b0, "divu_100_7");
        run_op(1'b1, 32'hFFFFFFF9,   32'd2,        0, 1'b0, "div_m7_2");
        run_op(1'b1, 32'd7,          32'hFFFFFFFE, 1, 1'b0, "div_7_m2");
        run_op(1'b0, 32'hFFFFFFFF,   32'h80000001, 0, 1'b0, "divu_big");
        run_op(1'b1, 32'h80000000,   32'hFFFFFFFF, 2, 1'b0, "div_ovf");
        run_op(1'b0, 32'd5,          32'd0,        0, 1'b0, "divu_zero");
        run_op(1'b1, 32'hFFFFFFFB,   32'd0,        0, 1'b0, "div_m5_zero");
        run_op(1'b1, 32'd5,          32'd0,        0, 1'b0, "div_5_zero");

        // Cancel during DIV step 10
        send(1'b0, 32'd1000, 32'd3);
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check_value("cancel_busy",   {63'd0, busy},    64'd0);
        check_value("cancel_sready", {63'd0, s_ready}, 64'd1);
        check_value("cancel_mvalid", {63'd0, m_valid}, 64'd0);
        any_valid = 1'b0;
        for (int i = 0; i < W + 8; i++) begin
            @(negedge clk);
            any_valid |= m_valid;
        end
        check_value("cancel_no_result", {63'd0, any_valid}, 64'd0);
        run_op(1'b0, 32'd9, 32'd3, 0, 1'b0, "after_cancel");

        // cancel together with s_valid in IDLE must not accept
        @(negedge clk);
        s_valid = 1'b1;
        cancel  = 1'b1;
        s_data0 = 32'd50;
        s_data1 = 32'd5;
        @(negedge clk);
        s_valid = 1'b0;
        cancel  = 1'b0;
        check_value("cancel_idle_busy", {63'd0, busy}, 64'd0);

        // Cancel of a result waiting in DONE
        send(1'b0, 32'd77, 32'd7);
        for (int i = 0; i <= W + 4; i++) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        check_value("done_wait_valid", {63'd0, m_valid}, 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check_value("done_cancel_valid",  {63'd0, m_valid}, 64'd0);
        check_value("done_cancel_sready", {63'd0, s_ready}, 64'd1);

        // Asynchronous reset mid-DIV
        send(1'b1, 32'hFFFFFF9C, 32'd7);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check_value("arst_sready", {63'd0, s_ready}, 64'd1);
        check_value("arst_mvalid", {63'd0, m_valid}, 64'd0);
        check_value("arst_busy",   {63'd0, busy},    64'd0);
        check_value("arst_q",      64'(m_quotient),  64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(1'b1, 32'hFFFFFF9C, 32'd7, 0, 1'b0, "after_reset");

        // Random operations with back-pressure and junk s_valid while busy
        for (int k = 0; k < 1000; k++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = rand_val(1'b0);
            b   = rand_val(1'b1);
            run_op(sgn, a, b, $urandom_range(0, 3), 1'b1, "rnd");
        end

        check_value("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
